// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 command-register and INTA stage.
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK2 = 2'd3
  } inta_state_e;

  localparam logic [2:0] OCW2_NSEOI = 3'b001;
  localparam logic [2:0] OCW2_SEOI  = 3'b011;

  localparam int ICW1_LTIM_BIT = 3;
  localparam int ICW1_SNGL_BIT = 1;
  localparam int ICW2_BASE_LSB = 3;
  localparam int ICW4_AEOI_BIT = 1;
  localparam int OCW2_CMD_LSB  = 5;
  localparam int OCW3_RR_BIT   = 1;
  localparam int OCW3_RIS_BIT  = 0;

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

endpackage

// File: rtl/pic_inta_sequencer.sv
// Two-pulse INTA sequencer: latches the acknowledged level, sets ISR, drives the vector.
// state | meaning
// IDLE  | waiting for first INTA fall; int_out follows the pending request
// ACK1  | first INTA pulse low; bus floated
// GAP   | between the two INTA pulses
// ACK2  | second INTA pulse low; vector driven on the bus
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_clear,
  input  logic       end_of_init,
  input  logic       aeoi,
  input  logic [4:0] vec_base,
  input  logic       pend_valid,
  input  logic [2:0] pend_level,
  input  logic       inta_n,
  output logic       int_out,
  output logic       isr_set,
  output logic [2:0] isr_set_level,
  output logic [7:0] vector_out,
  output logic       vector_oe,
  output logic       aeoi_req,
  output logic [2:0] aeoi_level
);

  inta_state_e state_q;
  logic       inta_prev_q;
  logic [2:0] cur_level_q;
  logic       spurious_q;
  logic       int_out_q;
  logic       isr_set_q;
  logic [2:0] isr_set_level_q;
  logic [7:0] vector_out_q;
  logic       vector_oe_q;

  logic inta_fall;
  logic inta_rise;

  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;

  // The parent registers this request so it can arbitrate against OCW2 EOIs.
  assign aeoi_req   = (state_q == ST_ACK2) & inta_rise & aeoi & ~spurious_q;
  assign aeoi_level = cur_level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      inta_prev_q     <= 1'b1;
      cur_level_q     <= '0;
      spurious_q      <= 1'b0;
      int_out_q       <= 1'b0;
      isr_set_q       <= 1'b0;
      isr_set_level_q <= '0;
      vector_out_q    <= '0;
      vector_oe_q     <= 1'b0;
    end else begin
      inta_prev_q <= inta_n;
      isr_set_q   <= 1'b0;
      if (init_clear) begin
        state_q     <= ST_IDLE;
        vector_oe_q <= 1'b0;
        int_out_q   <= pend_valid & end_of_init;
      end else begin
        case (state_q)
          ST_IDLE: begin
            int_out_q <= pend_valid & end_of_init;
            if (inta_fall) begin
              cur_level_q     <= pend_valid ? pend_level : SPURIOUS_LEVEL;
              spurious_q      <= ~pend_valid;
              isr_set_q       <= pend_valid;
              isr_set_level_q <= pend_valid ? pend_level : SPURIOUS_LEVEL;
              int_out_q       <= 1'b0;
              state_q         <= ST_ACK1;
            end
          end
          ST_ACK1: begin
            int_out_q <= 1'b0;
            if (inta_rise) state_q <= ST_GAP;
          end
          ST_GAP: begin
            int_out_q <= 1'b0;
            if (inta_fall) begin
              vector_out_q <= {vec_base, cur_level_q};
              vector_oe_q  <= 1'b1;
              state_q      <= ST_ACK2;
            end
          end
          ST_ACK2: begin
            int_out_q <= 1'b0;
            if (inta_rise) begin
              vector_oe_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign int_out       = int_out_q;
  assign isr_set       = isr_set_q;
  assign isr_set_level = isr_set_level_q;
  assign vector_out    = vector_out_q;
  assign vector_oe     = vector_oe_q;

endmodule

// File: rtl/pic_control_logic.sv
// 8259 command registers, strobe edge decode, readback mux and EOI command issue.
module pic_control_logic
  import pic_pkg::*;
#(
  parameter logic [4:0] VEC_BASE_RST = 5'b00000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:1] icw_strobe,
  input  logic [3:1] ocw_strobe,
  input  logic [7:0] cmd_data,
  input  logic       end_of_init,
  input  logic       a0,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  input  logic       pend_valid,
  input  logic [2:0] pend_level,
  input  logic       inta_n,
  output logic [7:0] imr,
  output logic       ltim,
  output logic       sngl,
  output logic       aeoi,
  output logic [7:0] readback,
  output logic       int_out,
  output logic       isr_set,
  output logic [2:0] isr_set_level,
  output logic       eoi_pulse,
  output logic       eoi_specific,
  output logic [2:0] eoi_level,
  output logic [7:0] vector_out,
  output logic       vector_oe
);

  logic [4:1] icw_prev_q;
  logic [3:1] ocw_prev_q;
  logic [7:0] imr_q;
  logic       ltim_q;
  logic       sngl_q;
  logic       aeoi_q;
  logic [4:0] base_q;
  logic [7:0] icw3_q;
  logic       rsel_q;
  logic       eoi_pulse_q;
  logic       eoi_specific_q;
  logic [2:0] eoi_level_q;

  logic [4:1] icw_rise_d;
  logic [3:1] ocw_rise_d;
  logic [2:0] ocw2_cmd_d;
  logic       ocw2_eoi_d;
  logic       aeoi_req;
  logic [2:0] aeoi_level;

  assign icw_rise_d = icw_strobe & ~icw_prev_q;
  // OCW writes before initialization completes are dropped entirely.
  assign ocw_rise_d = ocw_strobe & ~ocw_prev_q & {3{end_of_init}};
  assign ocw2_cmd_d = cmd_data[7:OCW2_CMD_LSB];
  assign ocw2_eoi_d = ocw_rise_d[2] &
                      ((ocw2_cmd_d == OCW2_NSEOI) | (ocw2_cmd_d == OCW2_SEOI));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icw_prev_q     <= '0;
      ocw_prev_q     <= '0;
      imr_q          <= '0;
      ltim_q         <= 1'b0;
      sngl_q         <= 1'b0;
      aeoi_q         <= 1'b0;
      base_q         <= VEC_BASE_RST;
      icw3_q         <= '0;
      rsel_q         <= 1'b0;
      eoi_pulse_q    <= 1'b0;
      eoi_specific_q <= 1'b0;
      eoi_level_q    <= '0;
    end else begin
      icw_prev_q     <= icw_strobe;
      ocw_prev_q     <= ocw_strobe;
      eoi_pulse_q    <= 1'b0;
      eoi_specific_q <= 1'b0;
      eoi_level_q    <= '0;
      if (icw_rise_d[1]) begin
        ltim_q <= cmd_data[ICW1_LTIM_BIT];
        sngl_q <= cmd_data[ICW1_SNGL_BIT];
        imr_q  <= '0;
        rsel_q <= 1'b0;
      end else begin
        if (icw_rise_d[2]) base_q <= cmd_data[7:ICW2_BASE_LSB];
        if (icw_rise_d[3]) icw3_q <= cmd_data;
        if (icw_rise_d[4]) aeoi_q <= cmd_data[ICW4_AEOI_BIT];
        if (ocw_rise_d[1]) imr_q  <= cmd_data;
        if (ocw_rise_d[3] && cmd_data[OCW3_RR_BIT]) rsel_q <= cmd_data[OCW3_RIS_BIT];
        // An explicit OCW2 EOI takes the single EOI slot over an automatic one.
        if (ocw2_eoi_d) begin
          eoi_pulse_q    <= 1'b1;
          eoi_specific_q <= (ocw2_cmd_d == OCW2_SEOI);
          eoi_level_q    <= (ocw2_cmd_d == OCW2_SEOI) ? cmd_data[2:0] : 3'd0;
        end else if (aeoi_req) begin
          eoi_pulse_q    <= 1'b1;
          eoi_specific_q <= 1'b1;
          eoi_level_q    <= aeoi_level;
        end
      end
    end
  end

  pic_inta_sequencer u_inta (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_clear    (icw_rise_d[1]),
    .end_of_init   (end_of_init),
    .aeoi          (aeoi_q),
    .vec_base      (base_q),
    .pend_valid    (pend_valid),
    .pend_level    (pend_level),
    .inta_n        (inta_n),
    .int_out       (int_out),
    .isr_set       (isr_set),
    .isr_set_level (isr_set_level),
    .vector_out    (vector_out),
    .vector_oe     (vector_oe),
    .aeoi_req      (aeoi_req),
    .aeoi_level    (aeoi_level)
  );

  assign readback     = a0 ? imr_q : (rsel_q ? isr : irr);
  assign imr          = imr_q;
  assign ltim         = ltim_q;
  assign sngl         = sngl_q;
  assign aeoi         = aeoi_q;
  assign eoi_pulse    = eoi_pulse_q;
  assign eoi_specific = eoi_specific_q;
  assign eoi_level    = eoi_level_q;

endmodule

// File: tb/tb_pic_control_logic.sv
// Self-checking bench for pic_control_logic: register-write vector table plus INTA sequences.
module tb_pic_control_logic;

  localparam logic [6:0] M_IMR = 7'h01, M_MODE = 7'h02, M_EOI = 7'h04, M_RB = 7'h08,
                         M_INT = 7'h10, M_ISR = 7'h20, M_VEC = 7'h40;
  localparam logic [7:0] IRR_V = 8'h3C, ISR_V = 8'h81;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:1] icw_strobe;
  logic [3:1] ocw_strobe;
  logic [7:0] cmd_data;
  logic       end_of_init, a0;
  logic [7:0] irr, isr;
  logic       pend_valid;
  logic [2:0] pend_level;
  logic       inta_n;
  logic [7:0] imr, readback, vector_out;
  logic       ltim, sngl, aeoi, int_out, isr_set, eoi_pulse, eoi_specific, vector_oe;
  logic [2:0] isr_set_level, eoi_level;

  int checks = 0;
  int failures = 0;

  pic_control_logic #(.VEC_BASE_RST(5'b00000)) dut (
    .clk(clk), .rst_n(rst_n), .icw_strobe(icw_strobe), .ocw_strobe(ocw_strobe),
    .cmd_data(cmd_data), .end_of_init(end_of_init), .a0(a0), .irr(irr), .isr(isr),
    .pend_valid(pend_valid), .pend_level(pend_level), .inta_n(inta_n),
    .imr(imr), .ltim(ltim), .sngl(sngl), .aeoi(aeoi), .readback(readback),
    .int_out(int_out), .isr_set(isr_set), .isr_set_level(isr_set_level),
    .eoi_pulse(eoi_pulse), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .vector_out(vector_out), .vector_oe(vector_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [6:0] mask;
    logic [7:0] imr;
    logic [2:0] mode;   // {ltim, sngl, aeoi}
    logic [4:0] eoi;    // {pulse, specific, level}
    logic [7:0] rb;
    logic       int_o;
    logic [3:0] isr;    // {pulse, level}
    logic [8:0] vec;    // {oe, vector}
  } exp_t;

  typedef struct {
    logic [3:0] icw;
    logic [2:0] ocw;
    logic [7:0] d;
    logic       a0;
    logic       eoi_init;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic exp_t ex(string tag, logic [6:0] mask, logic [7:0] imr_v,
                              logic [2:0] mode_v, logic [4:0] eoi_v, logic [7:0] rb_v,
                              logic int_v, logic [3:0] isr_v, logic [8:0] vec_v);
    exp_t e;
    e.tag = tag; e.mask = mask; e.imr = imr_v; e.mode = mode_v; e.eoi = eoi_v;
    e.rb = rb_v; e.int_o = int_v; e.isr = isr_v; e.vec = vec_v;
    return e;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_exp(exp_t e);
    if (e.mask[0]) chk({e.tag, ".imr"}, imr, e.imr);
    if (e.mask[1]) chk({e.tag, ".mode"}, 8'({ltim, sngl, aeoi}), 8'(e.mode));
    if (e.mask[2]) begin
      chk({e.tag, ".eoi_pulse"}, 8'(eoi_pulse), 8'(e.eoi[4]));
      if (e.eoi[4]) begin
        chk({e.tag, ".eoi_specific"}, 8'(eoi_specific), 8'(e.eoi[3]));
        if (e.eoi[3]) chk({e.tag, ".eoi_level"}, 8'(eoi_level), 8'(e.eoi[2:0]));
      end
    end
    if (e.mask[3]) chk({e.tag, ".readback"}, readback, e.rb);
    if (e.mask[4]) chk({e.tag, ".int_out"}, 8'(int_out), 8'(e.int_o));
    if (e.mask[5]) begin
      chk({e.tag, ".isr_set"}, 8'(isr_set), 8'(e.isr[3]));
      if (e.isr[3]) chk({e.tag, ".isr_set_level"}, 8'(isr_set_level), 8'(e.isr[2:0]));
    end
    if (e.mask[6]) begin
      chk({e.tag, ".vector_oe"}, 8'(vector_oe), 8'(e.vec[8]));
      if (e.vec[8]) chk({e.tag, ".vector_out"}, vector_out, e.vec[7:0]);
    end
  endtask

  // Expectation is queued with the stimulus and retired after the sampling edge.
  task automatic drive_step(exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_exp(got);
  endtask

  task automatic check_now(exp_t e);
    exp_t got;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check_exp(got);
  endtask

  task automatic add(string tag, logic [3:0] icw, logic [2:0] ocw, logic [7:0] d,
                     logic a0_v, logic eoi_init, logic [7:0] imr_v, logic [2:0] mode_v,
                     logic [4:0] eoi_v, logic [7:0] rb_v);
    vec_t v;
    v.icw = icw; v.ocw = ocw; v.d = d; v.a0 = a0_v; v.eoi_init = eoi_init;
    // pend_valid is held high through the table, so int_out tracks end_of_init.
    v.e = ex(tag, M_IMR | M_MODE | M_EOI | M_RB | M_INT, imr_v, mode_v, eoi_v, rb_v,
             eoi_init, 4'd0, 9'd0);
    tbl.push_back(v);
  endtask

  task automatic inta(logic v, exp_t e);
    inta_n = v;
    drive_step(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; icw_strobe = '0; ocw_strobe = '0; cmd_data = '0; end_of_init = 1'b0;
    a0 = 1'b0; irr = IRR_V; isr = ISR_V; pend_valid = 1'b1; pend_level = 3'd5; inta_n = 1'b1;

    //  tag          icw      ocw     data   a0 eoi imr    mode    eoi       readback
    add("icw1",      4'b0001, 3'b000, 8'h1B, 0, 0, 8'h00, 3'b110, 5'b00000, IRR_V);
    add("icw2",      4'b0010, 3'b000, 8'h40, 0, 0, 8'h00, 3'b110, 5'b00000, IRR_V);
    add("icw3",      4'b0100, 3'b000, 8'hFF, 0, 0, 8'h00, 3'b110, 5'b00000, IRR_V);
    add("icw4",      4'b1000, 3'b000, 8'h03, 0, 0, 8'h00, 3'b111, 5'b00000, IRR_V);
    add("ocw1_gate", 4'b0000, 3'b001, 8'hA5, 1, 0, 8'h00, 3'b111, 5'b00000, 8'h00);
    add("ocw1",      4'b0000, 3'b001, 8'hA5, 1, 1, 8'hA5, 3'b111, 5'b00000, 8'hA5);
    add("ocw3_isr",  4'b0000, 3'b100, 8'h0B, 0, 1, 8'hA5, 3'b111, 5'b00000, ISR_V);
    add("ocw3_keep", 4'b0000, 3'b100, 8'h01, 0, 1, 8'hA5, 3'b111, 5'b00000, ISR_V);
    add("ocw3_irr",  4'b0000, 3'b100, 8'h0A, 0, 1, 8'hA5, 3'b111, 5'b00000, IRR_V);
    add("ocw2_ns",   4'b0000, 3'b010, 8'h20, 0, 1, 8'hA5, 3'b111, 5'b10000, IRR_V);
    add("ocw2_sp",   4'b0000, 3'b010, 8'h63, 0, 1, 8'hA5, 3'b111, 5'b11011, IRR_V);
    add("ocw2_rot",  4'b0000, 3'b010, 8'hC0, 0, 1, 8'hA5, 3'b111, 5'b00000, IRR_V);
    add("ocw3_gate", 4'b0000, 3'b100, 8'h0B, 0, 0, 8'hA5, 3'b111, 5'b00000, IRR_V);
    add("icw1_prio", 4'b0001, 3'b001, 8'h13, 1, 1, 8'h00, 3'b011, 5'b00000, 8'h00);
    add("ocw1_b",    4'b0000, 3'b001, 8'h5A, 1, 1, 8'h5A, 3'b011, 5'b00000, 8'h5A);

    repeat (3) @(posedge clk);
    #1;
    check_now(ex("reset", M_IMR | M_MODE | M_EOI | M_RB | M_INT | M_ISR | M_VEC,
                 8'h00, 3'b000, 5'd0, IRR_V, 1'b0, 4'd0, 9'd0));
    chk("reset.vector_out", vector_out, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      icw_strobe = tbl[i].icw; ocw_strobe = tbl[i].ocw; cmd_data = tbl[i].d;
      a0 = tbl[i].a0; end_of_init = tbl[i].eoi_init;
      drive_step(tbl[i].e);
      icw_strobe = '0; ocw_strobe = '0;
      drive_step(ex({tbl[i].e.tag, "_rel"}, M_IMR | M_MODE | M_EOI, tbl[i].e.imr,
                    tbl[i].e.mode, 5'd0, 8'd0, 1'b0, 4'd0, 9'd0));
    end

    // Normal acknowledge of level 5 with automatic EOI; base 0x40.
    a0 = 1'b0; pend_valid = 1'b1; pend_level = 3'd5;
    drive_step(ex("A0_int", M_INT, 0, 0, 0, 0, 1'b1, 0, 0));
    inta(1'b0, ex("A1_ack1", M_INT | M_ISR | M_VEC, 0, 0, 0, 0, 1'b0, 4'b1101, 9'd0));
    pend_level = 3'd2;
    inta(1'b1, ex("A2_gap", M_INT | M_ISR | M_VEC, 0, 0, 0, 0, 1'b0, 4'd0, 9'd0));
    inta(1'b0, ex("A3_ack2", M_VEC | M_ISR | M_EOI, 0, 0, 0, 0, 0, 4'd0, {1'b1, 8'h45}));
    inta(1'b1, ex("A4_aeoi", M_VEC | M_EOI, 0, 0, 5'b11101, 0, 0, 0, 9'd0));
    drive_step(ex("A5_idle", M_EOI | M_INT, 0, 0, 5'd0, 0, 1'b1, 0, 0));

    // Spurious acknowledge: no ISR set, level 7 vector, no AEOI.
    pend_valid = 1'b0;
    drive_step(ex("B0_int", M_INT, 0, 0, 0, 0, 1'b0, 0, 0));
    inta(1'b0, ex("B1_ack1", M_ISR | M_VEC, 0, 0, 0, 0, 0, 4'd0, 9'd0));
    inta(1'b1, ex("B2_gap", M_VEC, 0, 0, 0, 0, 0, 0, 9'd0));
    inta(1'b0, ex("B3_ack2", M_VEC, 0, 0, 0, 0, 0, 0, {1'b1, 8'h47}));
    inta(1'b1, ex("B4_end", M_VEC | M_EOI, 0, 0, 5'd0, 0, 0, 0, 9'd0));

    // OCW2 non-specific EOI on the same clock as the AEOI: OCW2 wins.
    pend_valid = 1'b1; pend_level = 3'd1;
    inta(1'b0, ex("C1_ack1", M_ISR, 0, 0, 0, 0, 0, 4'b1001, 0));
    inta(1'b1, ex("C2_gap", M_VEC, 0, 0, 0, 0, 0, 0, 9'd0));
    inta(1'b0, ex("C3_ack2", M_VEC, 0, 0, 0, 0, 0, 0, {1'b1, 8'h41}));
    ocw_strobe = 3'b010; cmd_data = 8'h20;
    inta(1'b1, ex("C4_both", M_VEC | M_EOI, 0, 0, 5'b10000, 0, 0, 0, 9'd0));
    ocw_strobe = '0;
    drive_step(ex("C5_rel", M_EOI, 0, 0, 5'd0, 0, 0, 0, 0));

    // ICW1 in GAP aborts the sequence; the next INTA fall starts a fresh one.
    pend_level = 3'd6;
    inta(1'b0, ex("D1_ack1", M_ISR, 0, 0, 0, 0, 0, 4'b1110, 0));
    inta(1'b1, ex("D2_gap", M_VEC, 0, 0, 0, 0, 0, 0, 9'd0));
    icw_strobe = 4'b0001; cmd_data = 8'h1B; a0 = 1'b1;
    drive_step(ex("D3_icw1", M_IMR | M_MODE | M_EOI | M_RB | M_INT | M_ISR | M_VEC,
                  8'h00, 3'b111, 5'd0, 8'h00, 1'b1, 4'd0, 9'd0));
    icw_strobe = '0;
    drive_step(ex("D4_rel", M_VEC, 0, 0, 0, 0, 0, 0, 9'd0));
    inta(1'b0, ex("D5_fresh", M_ISR | M_VEC, 0, 0, 0, 0, 0, 4'b1110, 9'd0));
    inta(1'b1, ex("D6_gap", M_VEC, 0, 0, 0, 0, 0, 0, 9'd0));
    inta(1'b0, ex("D7_ack2", M_VEC, 0, 0, 0, 0, 0, 0, {1'b1, 8'h46}));
    inta(1'b1, ex("D8_aeoi", M_VEC | M_EOI, 0, 0, 5'b11110, 0, 0, 0, 9'd0));

    // Asynchronous reset while the vector is on the bus.
    ocw_strobe = 3'b001; cmd_data = 8'h5A;
    drive_step(ex("E0_imr", M_IMR | M_RB, 8'h5A, 0, 0, 8'h5A, 0, 0, 0));
    ocw_strobe = '0;
    drive_step(ex("E1_rel", M_IMR, 8'h5A, 0, 0, 0, 0, 0, 0));
    inta(1'b0, ex("E2_ack1", M_ISR, 0, 0, 0, 0, 0, 4'b1110, 0));
    inta(1'b1, ex("E3_gap", M_VEC, 0, 0, 0, 0, 0, 0, 9'd0));
    inta(1'b0, ex("E4_ack2", M_VEC, 0, 0, 0, 0, 0, 0, {1'b1, 8'h46}));
    #2;
    rst_n = 1'b0;
    check_now(ex("E5_rst", M_IMR | M_MODE | M_EOI | M_RB | M_INT | M_ISR | M_VEC,
                 8'h00, 3'b000, 5'd0, 8'h00, 1'b0, 4'd0, 9'd0));
    chk("E5_rst.vector_out", vector_out, 8'h00);
    inta_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_step(ex("E6_post", M_IMR | M_VEC, 8'h00, 0, 0, 0, 0, 0, 9'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_control_logic.md
# pic_control_logic

Clocked command-register and interrupt-acknowledge stage of the 8259 PIC. It sits directly downstream of the read/write module and consumes that module's ICW/OCW strobes and command byte. It holds the mode, vector-base, mask and read-select registers, and drives the byte the read/write module returns to the CPU. It runs the two-pulse INTA sequence, which sets the in-service level, places the vector on the bus and issues EOI commands to the ISR block.

## Interface
Parameters:
- `VEC_BASE_RST`, 5'b00000: reset value of the vector base T7..T3.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `icw_strobe` in [4:1]: ICW1..ICW4 written; level, held ≥1 cycle.
- `ocw_strobe` in [3:1]: OCW1..OCW3 written; level, held ≥1 cycle.
- `cmd_data` in 8: byte accompanying the strobe.
- `end_of_init` in 1: initialization complete.
- `a0` in 1: read address bit.
- `irr`, `isr` in 8 each: readback sources.
- `pend_valid` in 1: priority resolver has an unmasked pending request.
- `pend_level` in 3: that request's level.
- `inta_n` in 1: CPU acknowledge, active low, synchronous to `clk`.
- `imr` out 8: mask register.
- `ltim`, `sngl`, `aeoi` out 1 each: mode bits.
- `readback` out 8: byte returned to the CPU.
- `int_out` out 1: interrupt request to the CPU.
- `isr_set` out 1, `isr_set_level` out 3: one-cycle pulse that sets an ISR bit.
- `eoi_pulse` out 1, `eoi_specific` out 1, `eoi_level` out 3: one-cycle EOI command.
- `vector_out` out 8, `vector_oe` out 1: vector bus drive.

## Operation
Write decode:
- Rising-edge detect on each strobe bit using the registered previous value.
- Exactly one action per rising edge.

Command register writes:
- ICW1: `ltim`=d[3], `sngl`=d[1]. `imr` cleared to 0. Read select set to IRR. INTA FSM forced to IDLE.
- ICW2: vector base = d[7:3].
- ICW3: stored internally; no output.
- ICW4: `aeoi`=d[1].
- OCW1: `imr`=d.

OCW2 (decode on d[7:5]):
- 001: non-specific EOI; `eoi_specific`=0.
- 011: specific EOI; `eoi_level`=d[2:0].
- All other codes (rotate/priority) are no-ops.

OCW3:
- If d[1]=1, read select = d[0] (0 = IRR, 1 = ISR).
- Otherwise read select is unchanged.

Strobe gating:
- OCW strobes are ignored while `end_of_init`=0.
- ICW1 is accepted at any time and has priority over any simultaneous strobe.

Readback (combinational): `a0`=1 → `imr`; otherwise read select ? `isr` : `irr`.

INTA FSM states: IDLE, ACK1, GAP, ACK2.
- IDLE: `int_out` = `pend_valid` & `end_of_init`. On INTA fall:
  - latch `cur_level` = `pend_valid` ? `pend_level` : 7;
  - pulse `isr_set` only if `pend_valid` (otherwise spurious, level 7);
  - go to ACK1.
- ACK1: `int_out`=0, bus floated. On INTA rise → GAP.
- GAP: on INTA fall → ACK2, with `vector_out`={base, `cur_level`} and `vector_oe`=1.
- ACK2: on INTA rise:
  - `vector_oe`=0;
  - if `aeoi`=1 and the cycle was not spurious, pulse a specific EOI for `cur_level`;
  - go to IDLE.

## Timing
Reset values:
- `imr`=0, `ltim`=`sngl`=`aeoi`=0, base=`VEC_BASE_RST`, read select=IRR, state IDLE.
- All pulses 0, `vector_oe`=0, `vector_out`=0, `int_out`=0.

Latency:
- All outputs except `readback` are registered.
- Register updates and pulses appear one cycle after the clock that samples the strobe or INTA edge.

Simultaneous events:
- An ICW1 edge in any FSM state forces IDLE and suppresses the `isr_set`/EOI pulse of that cycle.
- `vector_oe` drops in the same update.

Other boundaries:
- An OCW2 EOI and an AEOI in the same cycle: the OCW2 command wins; the AEOI is dropped.
- `pend_valid` changing during ACK1/GAP has no effect, since `cur_level` is latched.
- Reset asserted mid-sequence returns every output to its reset value immediately.

## Structure
- Package `pic_pkg`:
  - FSM state enum;
  - OCW2 command codes (NSEOI=3'b001, SEOI=3'b011);
  - ICW/OCW field bit positions;
  - spurious level constant 3'd7.
- Sub-module `pic_inta_sequencer`: the INTA FSM, `cur_level` latch, and vector/ISR-set/AEOI outputs.
- The parent holds the register file, strobe edge detect and readback mux.

## Test plan
- Reset → `imr`=0, `vector_oe`=0, `int_out`=0, `readback`=`irr`.
- ICW1 0x1B, ICW2 0x40, ICW4 0x03 → `ltim`=1, `sngl`=1, `aeoi`=1. Full INTA with `pend_level`=5 → `vector_out`=0x45 in ACK2, then an EOI pulse with specific=1, level=5.
- OCW1 0xA5 → `imr`=0xA5; with `a0`=1, `readback`=0xA5. OCW3 0x0B → `readback`=`isr` with `a0`=0.
- OCW2 0x20 → `eoi_pulse`, specific=0. OCW2 0x63 → specific=1, level=3. OCW2 0xC0 → no pulse.
- First INTA fall with `pend_valid`=0 → no `isr_set`; vector = base|7; no AEOI pulse.
- ICW1 during GAP → state IDLE, `vector_oe` stays 0 on the next INTA fall, `imr`=0.
